// File: rtl/reorder_buffer_pkg.sv
// Shared types and helpers for the reorder buffer: instruction class codes,
// the "no destination register" marker and the branch redirect rule.
package reorder_buffer_pkg;

    localparam logic [5:0] REG_NULL = 6'b100000;

    typedef enum logic [1:0] {
        T_ALU       = 2'd0,
        T_BRANCH    = 2'd1,
        T_STORE     = 2'd2,
        T_JALR_LOAD = 2'd3
    } issue_type_e;

    function automatic logic [31:0] branch_redirect(
        input logic        taken,
        input logic [31:0] target,
        input logic [31:0] pc
    );
        return taken ? target : pc + 32'd4;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocate at tail, capture ALU/LSB CDB results, retire head.
// Commit/rollback outputs registered (one edge after head becomes ready); issue, query and full are combinational.
// Backpressure: rob_full blocks issue when all entries are live or a rollback pulse is out; rdy=0 freezes state.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,

    input  logic             issue_valid,
    input  logic [1:0]       issue_type,
    input  logic             issue_is_load,
    input  logic [5:0]       issue_rd,
    input  logic [31:0]      issue_pc,
    input  logic             issue_pred_taken,
    output logic             rob_full,
    output logic [IDX_W:0]   rob_new_entry,
    output logic             issue_sgn,

    input  logic             cdb_alu_valid,
    input  logic [IDX_W:0]   cdb_alu_entry,
    input  logic [31:0]      cdb_alu_value,
    input  logic             cdb_alu_taken,
    input  logic [31:0]      cdb_alu_target,
    input  logic             cdb_lsb_valid,
    input  logic [IDX_W:0]   cdb_lsb_entry,
    input  logic [31:0]      cdb_lsb_value,

    input  logic [IDX_W:0]   qj_entry,
    input  logic [IDX_W:0]   qk_entry,
    output logic             qj_ready,
    output logic [31:0]      qj_value,
    output logic             qk_ready,
    output logic [31:0]      qk_value,

    output logic             commit_sgn,
    output logic [IDX_W:0]   rob_entry,
    output logic [5:0]       rob_des,
    output logic [31:0]      rob_result,
    output logic             store_commit,
    output logic [IDX_W:0]   store_commit_entry,
    output logic             bp_update,
    output logic [31:0]      bp_update_pc,
    output logic             bp_update_taken,
    output logic             rollback,
    output logic [31:0]      rollback_pc
);

    localparam logic [IDX_W:0]   FULL_CNT = ROB_DEPTH[IDX_W:0];
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    logic             r_busy    [ROB_DEPTH];
    logic             r_ready   [ROB_DEPTH];
    issue_type_e      r_type    [ROB_DEPTH];
    logic             r_is_load [ROB_DEPTH];
    logic [5:0]       r_rd      [ROB_DEPTH];
    logic [31:0]      r_pc      [ROB_DEPTH];
    logic             r_pred    [ROB_DEPTH];
    logic [31:0]      r_value   [ROB_DEPTH];
    logic             r_taken   [ROB_DEPTH];
    logic [31:0]      r_target  [ROB_DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    logic [IDX_W-1:0] w_alu_idx;
    logic [IDX_W-1:0] w_lsb_idx;
    logic             w_wb_en;
    logic             w_alu_wr;
    logic             w_lsb_wr;
    logic             w_commit;
    logic             w_mispredict;
    logic             w_flush;

    assign rob_full      = (r_count == FULL_CNT) || rollback;
    assign issue_sgn     = issue_valid && !rob_full && rdy;
    assign rob_new_entry = {1'b0, r_tail};

    // The tag MSB is only ever set by ENTRY_NULL, so it alone marks "no entry".
    assign w_alu_idx = cdb_alu_entry[IDX_W-1:0];
    assign w_lsb_idx = cdb_lsb_entry[IDX_W-1:0];
    assign w_wb_en   = rdy && !rollback;
    assign w_alu_wr  = w_wb_en && cdb_alu_valid && !cdb_alu_entry[IDX_W] && r_busy[w_alu_idx];
    assign w_lsb_wr  = w_wb_en && cdb_lsb_valid && !cdb_lsb_entry[IDX_W] && r_busy[w_lsb_idx]
                       && !(cdb_alu_valid && cdb_alu_entry == cdb_lsb_entry);

    assign w_commit     = rdy && (r_count != '0) && r_ready[r_head];
    assign w_mispredict = (r_type[r_head] == T_BRANCH && r_taken[r_head] != r_pred[r_head])
                          || (r_type[r_head] == T_JALR_LOAD && !r_is_load[r_head]);
    assign w_flush      = w_commit && w_mispredict;

    function automatic logic [32:0] lookup(input logic [IDX_W:0] q);
        logic [IDX_W-1:0] i;
        i      = q[IDX_W-1:0];
        lookup = 33'd0;
        if (!q[IDX_W] && r_busy[i]) begin
            if (cdb_alu_valid && cdb_alu_entry == q)
                lookup = {1'b1, cdb_alu_value};
            else if (cdb_lsb_valid && cdb_lsb_entry == q)
                lookup = {1'b1, cdb_lsb_value};
            else if (r_ready[i])
                lookup = {1'b1, r_value[i]};
        end
    endfunction

    assign {qj_ready, qj_value} = lookup(qj_entry);
    assign {qk_ready, qk_value} = lookup(qk_entry);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head             <= '0;
            r_tail             <= '0;
            r_count            <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
            commit_sgn         <= 1'b0;
            rob_entry          <= '0;
            rob_des            <= '0;
            rob_result         <= '0;
            store_commit       <= 1'b0;
            store_commit_entry <= '0;
            bp_update          <= 1'b0;
            bp_update_pc       <= '0;
            bp_update_taken    <= 1'b0;
            rollback           <= 1'b0;
            rollback_pc        <= '0;
        end else begin
            commit_sgn         <= 1'b0;
            rob_entry          <= '0;
            rob_des            <= '0;
            rob_result         <= '0;
            store_commit       <= 1'b0;
            store_commit_entry <= '0;
            bp_update          <= 1'b0;
            bp_update_pc       <= '0;
            bp_update_taken    <= 1'b0;
            rollback           <= 1'b0;
            rollback_pc        <= '0;

            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                case (r_type[r_head])
                    T_ALU, T_JALR_LOAD: begin
                        commit_sgn <= 1'b1;
                        rob_entry  <= {1'b0, r_head};
                        rob_des    <= r_rd[r_head];
                        rob_result <= r_value[r_head];
                        if (r_type[r_head] == T_JALR_LOAD && !r_is_load[r_head]) begin
                            rollback    <= 1'b1;
                            rollback_pc <= r_target[r_head];
                        end
                    end
                    T_BRANCH: begin
                        bp_update       <= 1'b1;
                        bp_update_pc    <= r_pc[r_head];
                        bp_update_taken <= r_taken[r_head];
                        if (r_taken[r_head] != r_pred[r_head]) begin
                            rollback    <= 1'b1;
                            rollback_pc <= branch_redirect(r_taken[r_head], r_target[r_head], r_pc[r_head]);
                        end
                    end
                    default: begin
                        store_commit       <= 1'b1;
                        store_commit_entry <= {1'b0, r_head};
                        rob_des            <= REG_NULL;
                    end
                endcase
            end

            if (w_alu_wr) r_ready[w_alu_idx] <= 1'b1;
            if (w_lsb_wr) r_ready[w_lsb_idx] <= 1'b1;

            if (issue_sgn) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
            end

            // Later assignments win: a flush overrides the writeback and issue above.
            if (w_flush) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    r_busy[i]  <= 1'b0;
                    r_ready[i] <= 1'b0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_commit)  r_head <= r_head + IDX_ONE;
                if (issue_sgn) r_tail <= r_tail + IDX_ONE;
                r_count <= r_count + (IDX_W+1)'(issue_sgn) - (IDX_W+1)'(w_commit);
            end
        end
    end

    // Payload storage needs no reset; it is only observed behind busy/ready.
    always_ff @(posedge clk) begin
        if (w_alu_wr) begin
            r_value[w_alu_idx]  <= cdb_alu_value;
            r_taken[w_alu_idx]  <= cdb_alu_taken;
            r_target[w_alu_idx] <= cdb_alu_target;
        end
        if (w_lsb_wr)
            r_value[w_lsb_idx] <= cdb_lsb_value;
        if (issue_sgn) begin
            r_type[r_tail]    <= issue_type_e'(issue_type);
            r_is_load[r_tail] <= issue_is_load;
            r_rd[r_tail]      <= issue_rd;
            r_pc[r_tail]      <= issue_pc;
            r_pred[r_tail]    <= issue_pred_taken;
            r_value[r_tail]   <= '0;
            r_taken[r_tail]   <= 1'b0;
            r_target[r_tail]  <= '0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic, all checked
// against a queue-based program-order model of the buffer.
module tb_reorder_buffer;

    localparam int         DEPTH = 16;
    localparam logic [4:0] ENULL = 5'h10;
    localparam logic [5:0] RNULL = 6'h20;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_is_load, issue_pred_taken;
    logic [1:0]  issue_type;
    logic [5:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        rob_full, issue_sgn;
    logic [4:0]  rob_new_entry;
    logic        cdb_alu_valid, cdb_alu_taken, cdb_lsb_valid;
    logic [4:0]  cdb_alu_entry, cdb_lsb_entry;
    logic [31:0] cdb_alu_value, cdb_alu_target, cdb_lsb_value;
    logic [4:0]  qj_entry, qk_entry;
    logic        qj_ready, qk_ready;
    logic [31:0] qj_value, qk_value;
    logic        commit_sgn, store_commit, bp_update, bp_update_taken, rollback;
    logic [4:0]  rob_entry, store_commit_entry;
    logic [5:0]  rob_des;
    logic [31:0] rob_result, bp_update_pc, rollback_pc;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_DEPTH(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
        .rob_full(rob_full), .rob_new_entry(rob_new_entry), .issue_sgn(issue_sgn),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_entry(cdb_alu_entry), .cdb_alu_value(cdb_alu_value),
        .cdb_alu_taken(cdb_alu_taken), .cdb_alu_target(cdb_alu_target),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_entry(cdb_lsb_entry), .cdb_lsb_value(cdb_lsb_value),
        .qj_entry(qj_entry), .qk_entry(qk_entry),
        .qj_ready(qj_ready), .qj_value(qj_value), .qk_ready(qk_ready), .qk_value(qk_value),
        .commit_sgn(commit_sgn), .rob_entry(rob_entry), .rob_des(rob_des), .rob_result(rob_result),
        .store_commit(store_commit), .store_commit_entry(store_commit_entry),
        .bp_update(bp_update), .bp_update_pc(bp_update_pc), .bp_update_taken(bp_update_taken),
        .rollback(rollback), .rollback_pc(rollback_pc)
    );

    typedef struct {
        logic [4:0]  tag;
        logic [1:0]  typ;
        logic        ld;
        logic [5:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic        done;
        logic [31:0] val;
        logic        tk;
        logic [31:0] tgt;
    } ent_t;

    ent_t        m_q[$];
    int          m_tail;
    logic        e_commit, e_st, e_bp, e_bp_tk, e_rb;
    logic [4:0]  e_entry, e_st_entry;
    logic [5:0]  e_des;
    logic [31:0] e_result, e_bp_pc, e_rb_pc;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_expect();
        e_commit = 0; e_entry = 0; e_des = 0; e_result = 0;
        e_st = 0; e_st_entry = 0; e_bp = 0; e_bp_pc = 0; e_bp_tk = 0;
        e_rb = 0; e_rb_pc = 0;
    endtask

    task automatic check_regs();
        chk("commit_sgn", commit_sgn, e_commit);
        chk("rob_entry", rob_entry, e_entry);
        chk("rob_des", rob_des, e_des);
        chk("rob_result", rob_result, e_result);
        chk("store_commit", store_commit, e_st);
        chk("store_commit_entry", store_commit_entry, e_st_entry);
        chk("bp_update", bp_update, e_bp);
        chk("bp_update_pc", bp_update_pc, e_bp_pc);
        chk("bp_update_taken", bp_update_taken, e_bp_tk);
        chk("rollback", rollback, e_rb);
        chk("rollback_pc", rollback_pc, e_rb_pc);
    endtask

    function automatic int find(input logic [4:0] t);
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i].tag == t) return i;
        return -1;
    endfunction

    function automatic logic [32:0] model_query(input logic [4:0] t);
        int k;
        k = find(t);
        if (k < 0) return 33'd0;
        if (cdb_alu_valid && cdb_alu_entry == t) return {1'b1, cdb_alu_value};
        if (cdb_lsb_valid && cdb_lsb_entry == t) return {1'b1, cdb_lsb_value};
        if (m_q[k].done) return {1'b1, m_q[k].val};
        return 33'd0;
    endfunction

    task automatic idle();
        issue_valid = 0; issue_type = 0; issue_is_load = 0; issue_rd = 0;
        issue_pc = 0; issue_pred_taken = 0; rdy = 1;
        cdb_alu_valid = 0; cdb_alu_entry = ENULL; cdb_alu_value = 0;
        cdb_alu_taken = 0; cdb_alu_target = 0;
        cdb_lsb_valid = 0; cdb_lsb_entry = ENULL; cdb_lsb_value = 0;
        qj_entry = ENULL; qk_entry = ENULL;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic ld, input logic [5:0] rd,
                             input logic [31:0] pc, input logic pred);
        issue_valid = 1; issue_type = t; issue_is_load = ld; issue_rd = rd;
        issue_pc = pc; issue_pred_taken = pred;
    endtask

    task automatic set_alu(input logic [4:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
        cdb_alu_valid = 1; cdb_alu_entry = t; cdb_alu_value = v;
        cdb_alu_taken = tk; cdb_alu_target = tg;
    endtask

    task automatic set_lsb(input logic [4:0] t, input logic [31:0] v);
        cdb_lsb_valid = 1; cdb_lsb_entry = t; cdb_lsb_value = v;
    endtask

    // One clock: check combinational answers, advance the model, check registered outputs.
    task automatic step();
        logic        full_e, isg_e, prev_rb, flush;
        logic [32:0] qa;
        ent_t        h, n;
        int          k;
        #1;
        full_e = (m_q.size() == DEPTH) || e_rb;
        isg_e  = issue_valid && !full_e && rdy;
        chk("rob_full", rob_full, full_e);
        chk("rob_new_entry", rob_new_entry, 5'(m_tail));
        chk("issue_sgn", issue_sgn, isg_e);
        qa = model_query(qj_entry);
        chk("qj_ready", qj_ready, qa[32]);
        chk("qj_value", qj_value, qa[31:0]);
        qa = model_query(qk_entry);
        chk("qk_ready", qk_ready, qa[32]);
        chk("qk_value", qk_value, qa[31:0]);

        prev_rb = e_rb;
        clear_expect();
        flush = 0;
        if (rdy && m_q.size() > 0 && m_q[0].done) begin
            h = m_q.pop_front();
            if (h.typ == 2'd2) begin
                e_st = 1; e_st_entry = h.tag; e_des = RNULL;
            end else if (h.typ == 2'd1) begin
                e_bp = 1; e_bp_pc = h.pc; e_bp_tk = h.tk;
                if (h.tk != h.pred) begin
                    e_rb = 1; e_rb_pc = h.tk ? h.tgt : h.pc + 32'd4;
                end
            end else begin
                e_commit = 1; e_entry = h.tag; e_des = h.rd; e_result = h.val;
                if (h.typ == 2'd3 && !h.ld) begin
                    e_rb = 1; e_rb_pc = h.tgt;
                end
            end
            flush = e_rb;
        end
        if (rdy && !prev_rb) begin
            if (cdb_lsb_valid && !(cdb_alu_valid && cdb_alu_entry == cdb_lsb_entry)) begin
                k = find(cdb_lsb_entry);
                if (k >= 0) begin m_q[k].done = 1; m_q[k].val = cdb_lsb_value; end
            end
            if (cdb_alu_valid) begin
                k = find(cdb_alu_entry);
                if (k >= 0) begin
                    m_q[k].done = 1; m_q[k].val = cdb_alu_value;
                    m_q[k].tk = cdb_alu_taken; m_q[k].tgt = cdb_alu_target;
                end
            end
        end
        if (flush) begin
            m_q.delete();
            m_tail = 0;
        end else if (isg_e) begin
            n.tag = 5'(m_tail); n.typ = issue_type; n.ld = issue_is_load; n.rd = issue_rd;
            n.pc = issue_pc; n.pred = issue_pred_taken;
            n.done = 0; n.val = 0; n.tk = 0; n.tgt = 0;
            m_q.push_back(n);
            m_tail = (m_tail + 1) % DEPTH;
        end
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    // Called just after a falling edge; reset is asserted between clock edges.
    task automatic do_reset();
        idle();
        #2 rst = 0;
        #1;
        m_q.delete();
        m_tail = 0;
        clear_expect();
        check_regs();
        chk("rst_rob_full", rob_full, 1'b0);
        chk("rst_rob_new_entry", rob_new_entry, 5'd0);
        chk("rst_issue_sgn", issue_sgn, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    function automatic logic [4:0] pick_query();
        int r;
        r = $urandom_range(0, 99);
        if (r < 40) return cdb_alu_entry;
        if (r < 85) return 5'($urandom_range(0, 15));
        return ENULL;
    endfunction

    task automatic rand_stim(input int p_issue, input int p_wb, input bit flushy);
        int   r, k;
        ent_t e;
        idle();
        r = $urandom_range(0, 99);
        issue_valid   = ($urandom_range(0, 99) < p_issue);
        issue_is_load = 1'($urandom_range(0, 1));
        if (!flushy) begin
            issue_type = (r < 60) ? 2'd0 : (r < 80) ? 2'd2 : 2'd3;
            if (issue_type == 2'd3) issue_is_load = 1;
        end else begin
            issue_type = (r < 50) ? 2'd0 : (r < 70) ? 2'd1 : (r < 82) ? 2'd2 : 2'd3;
            if (issue_type == 2'd3) issue_is_load = (r < 95);
        end
        issue_rd         = ($urandom_range(0, 9) == 0) ? RNULL : 6'($urandom_range(0, 31));
        issue_pc         = $urandom & 32'hFFFF_FFFC;
        issue_pred_taken = 1'($urandom_range(0, 1));
        cdb_alu_value    = $urandom;
        cdb_alu_taken    = 1'($urandom_range(0, 1));
        cdb_alu_target   = $urandom & 32'hFFFF_FFFC;
        cdb_lsb_value    = $urandom;
        for (int t = 0; t < 2; t++) begin
            if (m_q.size() > 0 && $urandom_range(0, 99) < p_wb) begin
                k = $urandom_range(0, m_q.size() - 1);
                e = m_q[k];
                if (!e.done) begin
                    if (e.typ == 2'd2 || (e.typ == 2'd3 && e.ld)) begin
                        if (!cdb_lsb_valid && !(cdb_alu_valid && cdb_alu_entry == e.tag)) begin
                            cdb_lsb_valid = 1; cdb_lsb_entry = e.tag;
                        end
                    end else if (!cdb_alu_valid && !(cdb_lsb_valid && cdb_lsb_entry == e.tag)) begin
                        cdb_alu_valid = 1; cdb_alu_entry = e.tag;
                    end
                end
            end
        end
        if (!cdb_alu_valid && $urandom_range(0, 19) == 0) begin
            cdb_alu_valid = 1;
            cdb_alu_entry = ($urandom_range(0, 1) == 0) ? ENULL : 5'($urandom_range(0, 15));
        end
        rdy      = ($urandom_range(0, 15) != 0);
        qj_entry = pick_query();
        qk_entry = pick_query();
    endtask

    initial begin
        rst = 0;
        idle();
        clear_expect();
        m_tail = 0;
        @(negedge clk);
        do_reset();

        // Three ALU ops, written back 2,0,1, must retire 0,1,2.
        for (int i = 0; i < 3; i++) begin
            idle(); set_issue(2'd0, 0, 6'(i + 1), 32'h1000 + 32'(4 * i), 0); step();
        end
        idle(); set_alu(5'd2, 32'h2222, 0, 0); step();
        idle(); set_alu(5'd0, 32'h0000, 0, 0); set_lsb(ENULL, 32'h55); step();
        idle(); set_alu(5'd1, 32'h1111, 0, 0); step();
        idle(); repeat (4) step();

        // Same-cycle CDB bypass to a query.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle(); set_issue(2'd0, 0, 6'(i + 4), 32'h2000 + 32'(4 * i), 0); step();
        end
        idle(); set_alu(5'd5, 32'hDEAD, 0, 0); qj_entry = 5'd5; qk_entry = 5'd4; step();
        idle(); qj_entry = 5'd5; qk_entry = ENULL; step();

        // Fill to 16, refused 17th, then retire and issue around the wrap.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle(); set_issue(2'd0, 0, 6'(i), 32'h3000 + 32'(4 * i), 0); step();
        end
        idle(); set_issue(2'd0, 0, 6'd9, 32'h3100, 0); step();
        idle(); set_alu(5'd0, 32'hA0, 0, 0); set_issue(2'd0, 0, 6'd9, 32'h3100, 0); step();
        idle(); set_alu(5'd1, 32'hA1, 0, 0); step();
        idle(); set_issue(2'd0, 0, 6'd10, 32'h3104, 0); set_alu(5'd2, 32'hA2, 0, 0); step();
        idle(); set_issue(2'd0, 0, 6'd11, 32'h3108, 0); step();
        idle(); repeat (2) step();

        // Taken branch predicted not-taken: redirect to target, discard issue on the flush edge.
        do_reset();
        idle(); set_issue(2'd1, 0, RNULL, 32'h100, 0); step();
        idle(); set_alu(5'd0, 32'h0, 1, 32'h200); step();
        idle(); set_issue(2'd0, 0, 6'd5, 32'h104, 0); step();
        idle(); set_issue(2'd0, 0, 6'd5, 32'h200, 0); set_alu(5'd0, 32'h77, 0, 0); step();
        idle(); set_issue(2'd0, 0, 6'd6, 32'h204, 0); step();
        idle(); step();

        // Not-taken mispredict, correct prediction, JALR, store and load.
        do_reset();
        idle(); set_issue(2'd1, 0, RNULL, 32'h40, 1); step();
        idle(); set_alu(5'd0, 32'h0, 0, 32'h80); step();
        idle(); repeat (3) step();
        idle(); set_issue(2'd1, 0, RNULL, 32'h50, 1); step();
        idle(); set_issue(2'd2, 0, 6'd0, 32'h54, 0); set_alu(5'd0, 32'h0, 1, 32'h90); step();
        idle(); set_issue(2'd3, 1, 6'd7, 32'h58, 0); set_lsb(5'd1, 32'h1234); step();
        idle(); set_issue(2'd3, 0, 6'd1, 32'h5C, 0); set_lsb(5'd2, 32'hBEEF); step();
        idle(); set_alu(5'd3, 32'h60, 0, 32'h300); step();
        idle(); repeat (4) step();

        // rdy low for three cycles with a ready head.
        do_reset();
        idle(); set_issue(2'd0, 0, 6'd3, 32'h400, 0); step();
        idle(); set_alu(5'd0, 32'h4444, 0, 0); step();
        idle(); rdy = 0; set_issue(2'd0, 0, 6'd4, 32'h404, 0); step();
        idle(); rdy = 0; set_alu(5'd0, 32'h9999, 0, 0); step();
        idle(); rdy = 0; step();
        idle(); repeat (2) step();

        // Randomized traffic phases, with an asynchronous reset mid-stream.
        do_reset();
        for (int i = 0; i < 600; i++) begin rand_stim(85, 40, 0); step(); end
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rand_stim(70, 60, 1); step();
            if (i == 400) do_reset();
        end
        for (int i = 0; i < 400; i++) begin rand_stim(40, 80, 1); step(); end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
